// File: rtl/sa_result_drain.sv
// ============================================================================
// Module      : sa_result_drain
// Description : Snapshots the systolic-array result bus and drains it one row
//               per beat over a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_result_drain #(
  parameter int HPE   = 8,
  parameter int VPE   = 8,
  parameter int WIDTH = 16,
  parameter int RW    = (VPE > 1) ? $clog2(VPE) : 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [2*WIDTH*HPE*VPE-1:0] YY,
  input  logic                       start,
  output logic [2*WIDTH*HPE-1:0]     out_data,
  output logic [RW-1:0]              out_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
);

  localparam int          c_ROWW = 2 * WIDTH * HPE;
  localparam logic [RW-1:0] c_LAST = RW'(VPE - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [2*WIDTH*HPE*VPE-1:0] r_snap;
  logic [RW-1:0]              r_row;
  logic [c_ROWW-1:0]          r_data;
  logic                       r_valid;
  logic                       r_last;
  logic                       r_done;
  logic                       r_overrun;

  logic          w_acc;
  logic          w_load;
  logic          w_adv;
  logic          w_end;
  logic          w_ovr;
  logic [RW-1:0] w_row_inc;

  assign w_acc     = r_valid && out_ready;
  assign w_row_inc = r_row + RW'(1);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A start is honoured only when idle or when the final beat leaves this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_end       = 1'b0;
    w_ovr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_acc && r_last) begin
          w_end = 1'b1;
          if (start) w_load = 1'b1;
          else       w_state_nxt = S_IDLE;
        end else begin
          w_adv = w_acc;
          w_ovr = start;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_snap    <= '0;
      r_row     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= w_end;
      if (w_ovr) r_overrun <= 1'b1;
      if (w_load) begin
        r_snap  <= YY;
        r_row   <= '0;
        r_data  <= YY[c_ROWW-1:0];
        r_valid <= 1'b1;
        r_last  <= (VPE == 1);
      end else if (w_adv) begin
        r_row  <= w_row_inc;
        r_data <= r_snap[int'(w_row_inc)*c_ROWW +: c_ROWW];
        r_last <= (w_row_inc == c_LAST);
      end else if (w_end) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_row   = r_row;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign busy      = (r_state == S_STREAM);
  assign done      = r_done;
  assign overrun   = r_overrun;

endmodule

`default_nettype wire
